// File: rtl/wptr_full_ctrl.sv
// wptr_full_ctrl -- write-side pointer and full-flag logic of an async FIFO.
//
// Keeps the binary/Gray write pointer, brings the Gray read pointer across
// with a two-flop synchronizer and derives registered full, almost-full,
// fill-level and a sticky overflow flag, all in the wclk domain.
//
// Ports
//   wclk         in   write-domain clock, rising edge
//   wrst_n       in   synchronous active-low reset
//   winc         in   producer write request for this cycle
//   wclr_ovf     in   clear for the sticky overflow flag
//   rptr_async   in   Gray read pointer from the read domain (unsynchronized)
//   wen          out  memory write enable (winc & ~wfull), combinational
//   waddr        out  memory write address (low bits of the binary pointer)
//   wptr         out  registered Gray write pointer for the read domain
//   wfull        out  registered full flag
//   walmost_full out  registered almost-full flag
//   wlevel       out  registered fill estimate, 0..2^ADDRSIZE
//   woverflow    out  sticky: a write was attempted while full
module wptr_full_ctrl #(
  parameter int ADDRSIZE    = 4,
  parameter int AFULL_LEVEL = (1 << ADDRSIZE) - 2
) (
  input  logic                wclk,
  input  logic                wrst_n,
  input  logic                winc,
  input  logic                wclr_ovf,
  input  logic [ADDRSIZE:0]   rptr_async,
  output logic                wen,
  output logic [ADDRSIZE-1:0] waddr,
  output logic [ADDRSIZE:0]   wptr,
  output logic                wfull,
  output logic                walmost_full,
  output logic [ADDRSIZE:0]   wlevel,
  output logic                woverflow
);

  localparam logic [ADDRSIZE:0] AFULL_THR = (ADDRSIZE+1)'(AFULL_LEVEL);

  logic [ADDRSIZE:0] wbin;
  logic [ADDRSIZE:0] wbinnext;
  logic [ADDRSIZE:0] wgraynext;
  logic [ADDRSIZE:0] wq1_rptr;
  logic [ADDRSIZE:0] wq2_rptr;
  logic [ADDRSIZE:0] rbin_sync;
  logic [ADDRSIZE:0] level_next;
  logic [ADDRSIZE:0] full_pattern;

  // A request while full is dropped here; the memory never sees it.
  assign wen       = winc & ~wfull;
  assign waddr     = wbin[ADDRSIZE-1:0];
  assign wbinnext  = wbin + {{ADDRSIZE{1'b0}}, wen};
  assign wgraynext = (wbinnext >> 1) ^ wbinnext;

  // Gray to binary: each binary bit is the XOR of all Gray bits at or above it.
  always_comb begin
    rbin_sync = '0;
    for (int i = 0; i <= ADDRSIZE; i++)
      rbin_sync[i] = ^(wq2_rptr >> i);
  end

  // Full when the write pointer is exactly one lap (2^ADDRSIZE) ahead of the
  // synchronized read pointer; in Gray that flips the top two bits.
  assign full_pattern = {~wq2_rptr[ADDRSIZE:ADDRSIZE-1], wq2_rptr[ADDRSIZE-2:0]};

  // The synchronized read pointer lags the real one, so this level can only
  // overestimate occupancy -- full releases late, never early.
  assign level_next = wbinnext - rbin_sync;

  // Pointer and two-flop synchronizer; nothing sits between wq1 and wq2.
  always_ff @(posedge wclk) begin
    if (!wrst_n) begin
      wbin     <= '0;
      wptr     <= '0;
      wq1_rptr <= '0;
      wq2_rptr <= '0;
    end else begin
      wbin     <= wbinnext;
      wptr     <= wgraynext;
      wq1_rptr <= rptr_async;
      wq2_rptr <= wq1_rptr;
    end
  end

  // Status flags. Level at full is 2^ADDRSIZE, which is above AFULL_THR,
  // so almost-full is always set together with full.
  always_ff @(posedge wclk) begin
    if (!wrst_n) begin
      wfull        <= 1'b0;
      walmost_full <= 1'b0;
      wlevel       <= '0;
    end else begin
      wfull        <= (wgraynext == full_pattern);
      walmost_full <= (level_next >= AFULL_THR);
      wlevel       <= level_next;
    end
  end

  // Sticky overflow; a new overflow in the same cycle beats the clear.
  always_ff @(posedge wclk) begin
    if (!wrst_n)
      woverflow <= 1'b0;
    else if (winc && wfull)
      woverflow <= 1'b1;
    else if (wclr_ovf)
      woverflow <= 1'b0;
  end

endmodule

// File: tb/tb_wptr_full_ctrl.sv
module tb_wptr_full_ctrl;

  logic       wclk = 1'b0;
  logic       wrst_n = 1'b0;
  logic       winc = 1'b0;
  logic       wclr_ovf = 1'b0;
  logic [4:0] rptr_async = '0;
  logic       wen;
  logic [3:0] waddr;
  logic [4:0] wptr;
  logic       wfull;
  logic       walmost_full;
  logic [4:0] wlevel;
  logic       woverflow;

  wptr_full_ctrl #(.ADDRSIZE(4), .AFULL_LEVEL(14)) dut (
    .wclk(wclk), .wrst_n(wrst_n), .winc(winc), .wclr_ovf(wclr_ovf),
    .rptr_async(rptr_async), .wen(wen), .waddr(waddr), .wptr(wptr),
    .wfull(wfull), .walmost_full(walmost_full), .wlevel(wlevel),
    .woverflow(woverflow)
  );

  always #5 wclk = ~wclk;

  typedef struct {
    int wptr; int waddr; int wen; int wfull; int wafull; int wlevel; int wovf;
  } exp_t;

  exp_t q[$];
  int   n_total = 0;
  int   n_pass  = 0;

  // Reference model: write count, read count seen two edges late, flags
  // derived from occupancy = writes - reads (mod 32).
  int   m_wcnt = 0;
  int   m_lvl  = 0;
  int   m_full = 0;
  int   m_af   = 0;
  int   m_ovf  = 0;
  int   h1 = 0, h2 = 0;  // read counts sampled one and two edges ago
  int   rcnt = 0;        // reader's binary position, driven as Gray

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  task automatic step(input bit rst_n, input bit inc, input bit clr);
    exp_t e;
    int   acc, novf;
    @(negedge wclk);
    wrst_n     = rst_n;
    winc       = inc;
    wclr_ovf   = clr;
    rptr_async = 5'(rcnt ^ (rcnt >> 1));
    if (!rst_n) begin
      m_wcnt = 0; m_lvl = 0; m_full = 0; m_af = 0; m_ovf = 0; h1 = 0; h2 = 0;
    end else begin
      acc    = (inc && !m_full) ? 1 : 0;
      novf   = (inc && m_full) ? 1 : (clr ? 0 : m_ovf);
      m_wcnt = (m_wcnt + acc) % 32;
      m_lvl  = (m_wcnt - h2 + 32) % 32;
      m_full = (m_lvl == 16) ? 1 : 0;
      m_af   = (m_lvl >= 14) ? 1 : 0;
      m_ovf  = novf;
      h2 = h1;
      h1 = rcnt;
    end
    e.wptr   = m_wcnt ^ (m_wcnt >> 1);
    e.waddr  = m_wcnt % 16;
    e.wen    = (inc && !m_full) ? 1 : 0;
    e.wfull  = m_full;
    e.wafull = m_af;
    e.wlevel = m_lvl;
    e.wovf   = m_ovf;
    q.push_back(e);
  endtask

  // Monitor: one expected record per edge, compared just after the edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge wclk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("wptr",         int'(wptr),         e.wptr);
        chk("waddr",        int'(waddr),        e.waddr);
        chk("wen",          int'(wen),          e.wen);
        chk("wfull",        int'(wfull),        e.wfull);
        chk("walmost_full", int'(walmost_full), e.wafull);
        chk("wlevel",       int'(wlevel),       e.wlevel);
        chk("woverflow",    int'(woverflow),    e.wovf);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int la, lb;
    // reset, including reset winning over winc
    step(0, 0, 0); step(0, 0, 0); step(0, 1, 1);
    // fill 16 with reader parked at 0
    rcnt = 0;
    repeat (16) step(1, 1, 0);
    // overflow, sticky hold, clear
    step(1, 1, 0);
    repeat (3) step(1, 0, 0);
    step(1, 0, 1);
    step(1, 0, 0);
    // set and clear in the same cycle: set wins
    step(1, 1, 1);
    step(1, 0, 0);
    step(1, 0, 1);
    // drain visibility: reader jumps to 4
    rcnt = 4;
    repeat (4) step(1, 0, 0);
    // refill to full, then reset while full
    repeat (6) step(1, 1, 0);
    rcnt = 0;
    step(0, 1, 1);
    step(1, 0, 0);
    // 40 writes with the reader lagging two cycles: wraps, never full
    la = 0; lb = 0;
    for (int i = 0; i < 40; i++) begin
      rcnt = la;
      step(1, 1, 0);
      la = lb;
      lb = m_wcnt;
    end
    // mid-operation reset at level 9
    rcnt = 0;
    step(0, 0, 0);
    repeat (9) step(1, 1, 0);
    repeat (2) step(1, 0, 0);
    step(0, 0, 0);
    step(1, 0, 0);
    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      bit r, w, c;
      r = ($urandom % 120) != 0;
      w = ($urandom % 4) != 0;
      c = ($urandom % 8) == 0;
      if (!r) rcnt = 0;
      else if (($urandom % 3) == 0 && rcnt != m_wcnt) rcnt = (rcnt + 1) % 32;
      step(r, w, c);
    end
    repeat (3) @(negedge wclk);
    chk("scoreboard_drained", q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
